// File: rtl/serdes_pkg.sv
// serdes_pkg: shared defaults and state encoding for the serial deserializer.
package serdes_pkg;
   localparam logic [7:0] COM_DEF        = 8'hBC;
   localparam int         LOCK_COUNT_DEF = 4;
   localparam int         DK_TIMEOUT_DEF = 16;
   typedef enum logic [1:0] {SEARCH = 2'd0, LOCKING = 2'd1, ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/sync_fsm.sv
// sync_fsm: alignment state machine with COM lock counter and DK inactivity timeout.
module sync_fsm
   import serdes_pkg::*;
#(
   parameter int LOCK_COUNT = LOCK_COUNT_DEF,
   parameter int DK_TIMEOUT = DK_TIMEOUT_DEF
) (
   input  logic   clk,
   input  logic   reset_L,
   input  logic   dk,
   input  logic   com_hit,
   input  logic   boundary,
   output state_t state,
   output logic   active
);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int IW = $clog2(DK_TIMEOUT + 1);
   logic [CW-1:0] com_cnt;
   logic [IW-1:0] dk_idle;
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state   <= SEARCH;
         com_cnt <= '0;
         dk_idle <= '0;
         active  <= 1'b0;
      end else begin
         dk_idle <= dk ? '0 : (dk_idle == IW'(DK_TIMEOUT) ? dk_idle : dk_idle + 1'b1);
         // the edge on which dk_idle reaches DK_TIMEOUT is the one that drops lock
         if (!dk && state != SEARCH && dk_idle == IW'(DK_TIMEOUT - 1)) begin
            state   <= SEARCH;
            com_cnt <= '0;
            active  <= 1'b0;
         end else if (dk) begin
            case (state)
               SEARCH: if (com_hit) begin
                  state   <= LOCKING;
                  com_cnt <= CW'(1);
               end
               LOCKING: if (boundary) begin
                  if (!com_hit) begin
                     state   <= SEARCH;
                     com_cnt <= '0;
                  end else if (com_cnt == CW'(LOCK_COUNT - 1)) begin
                     state   <= ACTIVE;
                     com_cnt <= CW'(LOCK_COUNT);
                     active  <= 1'b1;
                  end else begin
                     com_cnt <= com_cnt + 1'b1;
                  end
               end
               ACTIVE: ;
               default: begin
                  state   <= SEARCH;
                  com_cnt <= '0;
                  active  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: rtl/deserializador_sync.sv
// deserializador_sync: MSB-first serial-to-byte converter with COM-based alignment,
// lock detection and DK inactivity timeout.
module deserializador_sync
   import serdes_pkg::*;
#(
   parameter logic [7:0] COM        = COM_DEF,
   parameter int         LOCK_COUNT = LOCK_COUNT_DEF,
   parameter int         DK_TIMEOUT = DK_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       in,
   input  logic       DK,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);
   logic [7:0] sr;
   logic [7:0] cand;
   logic [2:0] bit_cnt;
   logic       com_hit;
   logic       boundary;
   logic       emit;
   state_t     state;
   assign cand     = {sr[6:0], in};
   assign com_hit  = cand == COM;
   assign boundary = bit_cnt == 3'd7;
   assign emit     = DK && boundary && state == ACTIVE && !com_hit;
   sync_fsm #(.LOCK_COUNT(LOCK_COUNT), .DK_TIMEOUT(DK_TIMEOUT)) u_fsm (
      .clk      (clk),
      .reset_L  (reset_L),
      .dk       (DK),
      .com_hit  (com_hit),
      .boundary (boundary),
      .state    (state),
      .active   (active)
   );
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         sr        <= 8'h00;
         bit_cnt   <= 3'd0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
      end else begin
         valid_out <= emit;
         if (DK) begin
            sr      <= cand;
            // a COM seen while searching defines the new byte phase
            bit_cnt <= (state == SEARCH && com_hit) ? 3'd0 : bit_cnt + 3'd1;
         end
         if (emit) data_out <= cand;
      end
   end
endmodule

// File: tb/tb_deserializador_sync.sv
// tb_deserializador_sync: directed and random serial streams checked every cycle
// against a bit-queue reference model of the alignment/lock rules.
module tb_deserializador_sync;
   localparam logic [7:0] COM = 8'hBC;
   localparam int LOCK = 4;
   localparam int TMO  = 16;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       ser_in = 1'b0;
   logic       dk = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int checks = 0;
   int errors = 0;

   int         mode;
   bit         q[$];
   int         base;
   int         coms;
   int         idle;
   logic [7:0] exp_data;
   logic       exp_valid;
   logic       exp_active;

   int         n_valid;
   logic [7:0] last_data;

   deserializador_sync dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .in        (ser_in),
      .DK        (dk),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit expired, got running required finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] last8();
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) begin
         int idx = q.size() - 8 + i;
         v = {v[6:0], idx >= 0 ? q[idx] : 1'b0};
      end
      return v;
   endfunction

   function automatic void model_reset();
      mode = 0; q.delete(); base = 0; coms = 0; idle = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_active = 1'b0;
   endfunction

   // mode: 0 searching, 1 counting COMs, 2 locked
   function automatic void model_edge(bit b, bit v);
      logic [7:0] c;
      exp_valid = 1'b0;
      if (v) begin
         idle = 0;
         q.push_back(b);
         if (q.size() > 64) begin
            void'(q.pop_front());
            base--;
         end
         c = last8();
         if (mode == 0) begin
            if (c == COM) begin
               mode = 1; coms = 1; base = q.size();
            end
         end else if ((q.size() - base) % 8 == 0) begin
            if (mode == 1) begin
               if (c != COM) mode = 0;
               else if (++coms == LOCK) mode = 2;
            end else if (c != COM) begin
               exp_data = c; exp_valid = 1'b1;
            end
         end
      end else begin
         idle++;
         if (idle == TMO && mode != 0) mode = 0;
      end
      exp_active = mode == 2;
   endfunction

   task automatic send_bit(input bit b, input bit v);
      @(negedge clk);
      ser_in = b;
      dk = v;
      @(posedge clk);
      model_edge(b, v);
      #1;
      check("valid_out", valid_out, exp_valid);
      check("active", active, exp_active);
      check("data_out", data_out, exp_data);
      if (valid_out) begin
         n_valid++;
         last_data = data_out;
      end
   endtask

   task automatic send_idle(input int n);
      repeat (n) send_bit(1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1);
   endtask

   task automatic send_byte_gappy(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         if ($urandom_range(0, 15) == 0) send_idle($urandom_range(1, 20));
         send_bit(b[i], 1'b1);
      end
   endtask

   task automatic send_coms(input int n);
      repeat (n) send_byte(COM);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset_L = 1'b0;
      #1;
      model_reset();
      check("rst_valid", valid_out, 1'b0);
      check("rst_active", active, 1'b0);
      check("rst_data", data_out, 8'h00);
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   initial begin
      model_reset();
      #1;
      check("por_valid", valid_out, 1'b0);
      check("por_active", active, 1'b0);
      check("por_data", data_out, 8'h00);
      repeat (2) @(negedge clk);
      reset_L = 1'b1;

      // aligned lock, two data bytes
      n_valid = 0;
      send_coms(3);
      send_byte(COM);
      check("lock_after_4_com", active, 1'b1);
      send_byte(8'hA5);
      check("first_byte", last_data, 8'hA5);
      send_byte(8'h3C);
      check("aligned_count", n_valid, 2);
      check("second_byte", last_data, 8'h3C);

      // same stream at a 3-bit offset
      do_reset();
      n_valid = 0;
      send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
      send_coms(4);
      send_byte(8'hA5);
      send_byte(8'h3C);
      check("offset_count", n_valid, 2);
      check("offset_last", last_data, 8'h3C);

      // aborted lock
      do_reset();
      n_valid = 0;
      send_coms(2);
      send_byte(8'h55);
      check("abort_inactive", active, 1'b0);
      send_coms(4);
      send_byte(8'h7E);
      check("abort_count", n_valid, 1);
      check("abort_data", last_data, 8'h7E);

      // short DK gap inside a byte
      n_valid = 0;
      for (int i = 7; i >= 4; i--) send_bit(1'((8'hC3 >> i) & 1), 1'b1);
      send_idle(5);
      check("gap5_active", active, 1'b1);
      for (int i = 3; i >= 0; i--) send_bit(1'((8'hC3 >> i) & 1), 1'b1);
      check("gap5_count", n_valid, 1);
      check("gap5_data", last_data, 8'hC3);

      // timeout drops lock, data suppressed until relock
      n_valid = 0;
      send_idle(15);
      check("gap15_active", active, 1'b1);
      send_idle(1);
      check("gap16_active", active, 1'b0);
      send_byte(8'hA5);
      send_coms(4);
      check("relock_active", active, 1'b1);
      send_byte(8'h3C);
      check("timeout_count", n_valid, 1);
      check("timeout_data", last_data, 8'h3C);

      // reset mid-byte then full relock
      for (int i = 7; i >= 3; i--) send_bit(1'((8'h96 >> i) & 1), 1'b1);
      do_reset();
      n_valid = 0;
      send_byte(8'h12);
      send_coms(3);
      send_byte(8'h34);
      check("post_rst_count", n_valid, 0);
      send_coms(4);
      send_byte(8'h56);
      check("post_rst_relock", n_valid, 1);

      // random streams with junk, idle COMs and DK gaps
      repeat (40) begin
         if ($urandom_range(0, 9) == 0) do_reset();
         repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)), 1'b1);
         send_coms($urandom_range(2, 5));
         repeat ($urandom_range(1, 6))
            send_byte_gappy($urandom_range(0, 3) == 0 ? COM : 8'($urandom_range(0, 255)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/deserializador_sync.md
DESERIALIZADOR_SYNC -- requirements
Module: deserializador_sync

Interface
REQ-001 Parameter COM, default 8'hBC: comma/idle symbol used for byte alignment.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive aligned COM bytes required to declare lock.
REQ-003 Parameter DK_TIMEOUT, default 16: consecutive cycles with DK low that force loss of lock.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 in  input  1  serial data, MSB of each byte first.
REQ-007 DK  input  1  bit-valid qualifier; 1 = `in` carries a valid bit this cycle.
REQ-008 data_out  output  8  last completed non-COM byte.
REQ-009 valid_out  output  1  one-cycle pulse marking a new byte on data_out.
REQ-010 active  output  1  1 while the block is in state ACTIVE.

Function
REQ-011 Shift register: sr <= {sr[6:0], in} only on edges where DK=1; it holds when DK=0.
REQ-012 Bit counter bit_cnt (3 bits) advances only on edges where DK=1 and wraps from 7 to 0; the byte boundary is an edge with DK=1 and bit_cnt=7.
REQ-013 The candidate byte at any edge is {sr[6:0], in}.
REQ-014 States are SEARCH, LOCKING and ACTIVE, encoded in 2 bits.
REQ-015 SEARCH: on any edge with DK=1 and candidate==COM, set bit_cnt to 0, set com_cnt to 1 and move to LOCKING; otherwise remain.
REQ-016 LOCKING: at each byte boundary, a candidate equal to COM increments com_cnt, and a candidate not equal to COM returns the block to SEARCH with com_cnt=0.
REQ-017 LOCKING moves to ACTIVE at the boundary where com_cnt would reach LOCK_COUNT.
REQ-018 Consequence of REQ-015 to REQ-017: ACTIVE is entered at the boundary of the LOCK_COUNT-th COM, counting the COM matched in SEARCH.
REQ-019 ACTIVE, byte boundary with a non-COM candidate: data_out <= candidate and valid_out <= 1 on that same edge, so the byte is visible in the following cycle.
REQ-020 ACTIVE, byte boundary with a COM candidate: treated as idle; data_out holds and valid_out <= 0.
REQ-021 valid_out SHALL be 0 on every edge that is not an ACTIVE non-COM byte boundary, so it never stays high for two consecutive cycles.
REQ-022 Boundaries occurring before ACTIVE is entered never produce valid_out.
REQ-023 dk_idle counter: cleared on every edge with DK=1 and incremented (saturating) on edges with DK=0.
REQ-024 When dk_idle reaches DK_TIMEOUT in LOCKING or ACTIVE, the block moves to SEARCH and clears com_cnt; sr and bit_cnt hold their values.
REQ-025 DK low for fewer than DK_TIMEOUT cycles only pauses the block: alignment and state are kept.
REQ-026 active SHALL equal (state==ACTIVE) as a registered output.
REQ-027 Leaving ACTIVE drops active on the same edge and does not alter data_out.

Reset
REQ-028 While reset_L=0, independent of clk: state=SEARCH, sr=8'h00, bit_cnt=0, com_cnt=0, dk_idle=0, data_out=8'h00, valid_out=0, active=0.
REQ-029 Reset asserted mid-byte discards the partial byte; after release the block returns to SEARCH and re-acquires alignment.
REQ-030 reset_L release is synchronised externally; the block assumes release clean to clk.

Structure
REQ-031 A shared package serdes_pkg holds the default COM value (8'hBC), the state encoding (SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2) and the default LOCK_COUNT and DK_TIMEOUT.
REQ-032 One sub-module, sync_fsm, holds the state register, com_cnt and dk_idle; the shift register, bit counter and output registers stay in the top module.
REQ-033 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-034 Stream with DK=1 of 4x BC then A5, 3C, MSB first -> active rises at the 4th BC boundary; valid_out pulses with data_out=A5, then with data_out=3C, 8 cycles apart.
REQ-035 Same stream preceded by 3 junk bits (1,0,1) -> BC found at the bit offset; byte output identical to REQ-034.
REQ-036 Stream BC, BC, 55, then 4x BC, 7E -> LOCKING aborts to SEARCH at 55; lock re-acquired; only 7E is output.
REQ-037 In ACTIVE, DK low for 5 cycles in the middle of byte C3 -> no loss of lock; valid_out with data_out=C3 once DK resumes.
REQ-038 In ACTIVE, DK low for 16 cycles -> active falls on the 16th cycle; the next bytes are not output until 4 COMs are seen again.
REQ-039 reset_L pulsed low in ACTIVE mid-byte -> all outputs 0 immediately; full re-lock is required before the next valid_out.
